// File: rtl/hit_scorer.sv
// hit_scorer: per-hit score generator feeding the BCD score accumulator.
// Tracks the game phase (IDLE/PLAY/END), keeps BCD combo and max-combo
// counters and emits a 4-digit BCD per-hit score with a one-cycle strobe.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_game_start pulse: enter or restart PLAY (wins over i_game_end)
//   i_game_end   pulse: PLAY -> END
//   i_hit_valid  judged note event this cycle
//   i_hit_grade  00 miss, 01 good, 10 great, 11 perfect
//   o_score      BCD per-hit points, nonzero only while o_accum_now=1
//   o_accum_now  one-cycle strobe per scored hit
//   o_combo      current BCD combo (3 digits)
//   o_max_combo  highest BCD combo this game
//   o_full_combo in END: no miss occurred and at least one hit
//   o_playing    state is PLAY
module hit_scorer #(
  parameter logic [15:0] PTS_PERFECT = 16'h0010,
  parameter logic [15:0] PTS_GREAT   = 16'h0008,
  parameter logic [15:0] PTS_GOOD    = 16'h0005,
  parameter logic [11:0] COMBO_MAX   = 12'h999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_game_start,
  input  logic        i_game_end,
  input  logic        i_hit_valid,
  input  logic [1:0]  i_hit_grade,
  output logic [15:0] o_score,
  output logic        o_accum_now,
  output logic [11:0] o_combo,
  output logic [11:0] o_max_combo,
  output logic        o_full_combo,
  output logic        o_playing
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_END  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_score;
  logic        r_accum_now;
  logic [11:0] r_combo;
  logic [11:0] r_max_combo;
  logic        r_full_combo;
  logic        r_playing;
  logic        r_miss;

  logic        w_hit;
  logic        w_is_miss;
  logic [11:0] w_newc;
  logic [3:0]  w_bonus;
  logic [7:0]  w_base;
  logic [15:0] w_hit_score;
  logic [11:0] w_combo_next;
  logic [11:0] w_max_next;
  logic        w_miss_next;

  // BCD +1 on three digits with decimal carry, saturating at COMBO_MAX.
  // BCD values order the same way as their binary encodings, so >= works.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
    logic [11:0] r;
    if (v >= COMBO_MAX) begin
      r = COMBO_MAX;
    end else if (v[3:0] != 4'd9) begin
      r = {v[11:4], v[3:0] + 4'd1};
    end else if (v[7:4] != 4'd9) begin
      r = {v[11:8], v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[11:8] + 4'd1, 8'h00};
    end
    return r;
  endfunction

  // Two-digit BCD base plus a single-digit bonus; the sum stays below 100.
  function automatic logic [15:0] bcd_add_bonus(input logic [7:0] base, input logic [3:0] bonus);
    logic [4:0] ones;
    logic [3:0] tens;
    ones = {1'b0, base[3:0]} + {1'b0, bonus};
    if (ones > 5'd9) begin
      ones = ones - 5'd10;
      tens = base[7:4] + 4'd1;
    end else begin
      tens = base[7:4];
    end
    return {8'h00, tens, ones[3:0]};
  endfunction

  // Next-state values for the hit path; a hit coincident with game_start is dropped.
  always_comb begin
    w_hit     = (r_state == ST_PLAY) && !i_game_start && i_hit_valid;
    w_is_miss = (i_hit_grade == 2'b00);
    w_newc    = bcd_inc_sat(r_combo);

    case (i_hit_grade)
      2'b01:   w_base = PTS_GOOD[7:0];
      2'b10:   w_base = PTS_GREAT[7:0];
      2'b11:   w_base = PTS_PERFECT[7:0];
      default: w_base = 8'h00;
    endcase

    if (w_newc >= 12'h100) begin
      w_bonus = 4'd5;
    end else if (w_newc >= 12'h050) begin
      w_bonus = 4'd2;
    end else if (w_newc >= 12'h010) begin
      w_bonus = 4'd1;
    end else begin
      w_bonus = 4'd0;
    end

    w_hit_score  = bcd_add_bonus(w_base, w_bonus);
    w_combo_next = r_combo;
    w_max_next   = r_max_combo;
    w_miss_next  = r_miss;
    if (w_hit && w_is_miss) begin
      w_combo_next = 12'h000;
      w_miss_next  = 1'b1;
    end else if (w_hit) begin
      w_combo_next = w_newc;
      if (w_newc > r_max_combo) begin
        w_max_next = w_newc;
      end else begin
        w_max_next = r_max_combo;
      end
    end else begin
      w_combo_next = r_combo;
    end
  end

  // Game FSM plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_score      <= 16'h0000;
      r_accum_now  <= 1'b0;
      r_combo      <= 12'h000;
      r_max_combo  <= 12'h000;
      r_full_combo <= 1'b0;
      r_playing    <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      // Strobe and score default low; only a scored hit raises them.
      r_score     <= 16'h0000;
      r_accum_now <= 1'b0;
      if (i_game_start) begin
        r_state      <= ST_PLAY;
        r_playing    <= 1'b1;
        r_combo      <= 12'h000;
        r_max_combo  <= 12'h000;
        r_miss       <= 1'b0;
        r_full_combo <= 1'b0;
      end else begin
        case (r_state)
          ST_PLAY: begin
            r_combo     <= w_combo_next;
            r_max_combo <= w_max_next;
            r_miss      <= w_miss_next;
            if (w_hit && !w_is_miss) begin
              r_score     <= w_hit_score;
              r_accum_now <= 1'b1;
            end else begin
              r_accum_now <= 1'b0;
            end
            // Uses the post-hit values so a hit on the final cycle counts.
            if (i_game_end) begin
              r_state      <= ST_END;
              r_playing    <= 1'b0;
              r_full_combo <= !w_miss_next && (w_max_next != 12'h000);
            end else begin
              r_state <= ST_PLAY;
            end
          end
          ST_IDLE: r_state <= ST_IDLE;
          ST_END:  r_state <= ST_END;
          default: begin
            r_state   <= ST_IDLE;
            r_playing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_score      = r_score;
  assign o_accum_now  = r_accum_now;
  assign o_combo      = r_combo;
  assign o_max_combo  = r_max_combo;
  assign o_full_combo = r_full_combo;
  assign o_playing    = r_playing;

endmodule

// File: tb/tb_hit_scorer.sv
// Self-checking bench for hit_scorer: table-driven vectors with a score
// scoreboard, plus hand-written saturation and mid-stream reset sequences.
module tb_hit_scorer;

  logic        clk;
  logic        rst_n;
  logic        game_start;
  logic        game_end;
  logic        hit_valid;
  logic [1:0]  hit_grade;
  logic [15:0] score;
  logic        accum_now;
  logic [11:0] combo;
  logic [11:0] max_combo;
  logic        full_combo;
  logic        playing;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        st;
    logic        en;
    logic        hv;
    logic [1:0]  gr;
    logic        e_acc;
    logic [15:0] e_score;
    logic [11:0] e_combo;
    logic [11:0] e_max;
    logic        e_fc;
    logic        e_play;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];

  hit_scorer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_game_start (game_start),
    .i_game_end   (game_end),
    .i_hit_valid  (hit_valid),
    .i_hit_grade  (hit_grade),
    .o_score      (score),
    .o_accum_now  (accum_now),
    .o_combo      (combo),
    .o_max_combo  (max_combo),
    .o_full_combo (full_combo),
    .o_playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int k);
    logic [11:0] r;
    r[11:8] = 4'((k / 100) % 10);
    r[7:4]  = 4'((k / 10) % 10);
    r[3:0]  = 4'(k % 10);
    return r;
  endfunction

  function automatic void add(input logic st, input logic en, input logic hv, input logic [1:0] gr,
                              input logic e_acc, input logic [15:0] e_score, input logic [11:0] e_combo,
                              input logic [11:0] e_max, input logic e_fc, input logic e_play);
    vec_t v;
    v.st = st; v.en = en; v.hv = hv; v.gr = gr;
    v.e_acc = e_acc; v.e_score = e_score; v.e_combo = e_combo;
    v.e_max = e_max; v.e_fc = e_fc; v.e_play = e_play;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then compare outputs #1 after the edge.
  task automatic apply(input vec_t v, input string tag);
    game_start = v.st;
    game_end   = v.en;
    hit_valid  = v.hv;
    hit_grade  = v.gr;
    if (v.e_acc) sb.push_back(v.e_score);
    @(posedge clk);
    #1;
    chk({tag, " accum_now"}, 32'(accum_now), 32'(v.e_acc));
    if (accum_now) begin
      if (sb.size() == 0) begin
        chk({tag, " unexpected strobe"}, 32'd1, 32'd0);
      end else begin
        chk({tag, " score"}, 32'(score), 32'(sb.pop_front()));
      end
    end else begin
      chk({tag, " idle score"}, 32'(score), 32'h0);
    end
    chk({tag, " combo"}, 32'(combo), 32'(v.e_combo));
    chk({tag, " max_combo"}, 32'(max_combo), 32'(v.e_max));
    chk({tag, " full_combo"}, 32'(full_combo), 32'(v.e_fc));
    chk({tag, " playing"}, 32'(playing), 32'(v.e_play));
  endtask

  initial begin
    vec_t v;
    logic [11:0] c;
    logic [15:0] s;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    game_start = 1'b0; game_end = 1'b0; hit_valid = 1'b0; hit_grade = 2'b00;
    #2;
    chk("reset score", 32'(score), 32'h0);
    chk("reset accum", 32'(accum_now), 32'h0);
    chk("reset combo", 32'(combo), 32'h0);
    chk("reset max", 32'(max_combo), 32'h0);
    chk("reset fc", 32'(full_combo), 32'h0);
    chk("reset playing", 32'(playing), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // st en hv gr | acc score combo max fc play
    add(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 12'h000, 12'h000, 1'b0, 1'b0); // hit in IDLE
    add(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 12'h000, 12'h000, 1'b0, 1'b1); // start
    add(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 16'h0010, 12'h001, 12'h001, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 16'h0010, 12'h002, 12'h002, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 16'h0010, 12'h003, 12'h003, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 12'h003, 12'h003, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 12'h000, 12'h000, 1'b0, 1'b1); // hit + restart ignored
    for (int k = 1; k <= 11; k++) begin
      add(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, (k >= 10) ? 16'h0009 : 16'h0008,
          to_bcd(k), to_bcd(k), 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 12'h000, 12'h011, 1'b0, 1'b1); // miss
    add(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 16'h0010, 12'h001, 12'h011, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 16'h0010, 12'h002, 12'h011, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 12'h002, 12'h011, 1'b0, 1'b0); // end after miss
    add(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 12'h002, 12'h011, 1'b0, 1'b0); // hit in END
    add(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 12'h000, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 16'h0005, 12'h001, 12'h001, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 16'h0005, 12'h002, 12'h002, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 16'h0005, 12'h003, 12'h003, 1'b1, 1'b0); // hit + end
    add(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 12'h003, 12'h003, 1'b1, 1'b0); // fc holds
    add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 12'h000, 12'h000, 1'b0, 1'b1); // start beats end

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // 1000-hit run: good at combo 50, perfect elsewhere; saturates at 999.
    for (int k = 1; k <= 1000; k++) begin
      c = (k > 999) ? 12'h999 : to_bcd(k);
      if (k == 50) begin
        s = 16'h0007;
      end else if (k >= 100) begin
        s = 16'h0015;
      end else if (k >= 50) begin
        s = 16'h0012;
      end else if (k >= 10) begin
        s = 16'h0011;
      end else begin
        s = 16'h0010;
      end
      v.st = 1'b0; v.en = 1'b0; v.hv = 1'b1; v.gr = (k == 50) ? 2'b01 : 2'b11;
      v.e_acc = 1'b1; v.e_score = s; v.e_combo = c; v.e_max = c; v.e_fc = 1'b0; v.e_play = 1'b1;
      apply(v, $sformatf("run%0d", k));
    end

    // Asynchronous reset in the middle of the stream.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst score", 32'(score), 32'h0);
    chk("midrst accum", 32'(accum_now), 32'h0);
    chk("midrst combo", 32'(combo), 32'h0);
    chk("midrst max", 32'(max_combo), 32'h0);
    chk("midrst playing", 32'(playing), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    v.st = 1'b0; v.en = 1'b0; v.hv = 1'b1; v.gr = 2'b11;
    v.e_acc = 1'b0; v.e_score = 16'h0000; v.e_combo = 12'h000; v.e_max = 12'h000;
    v.e_fc = 1'b0; v.e_play = 1'b0;
    apply(v, "post-reset idle");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
